// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus definitions: transfer direction, response status codes
// and small sizing helpers used across the rggen RTL.
package rggen_rtl_pkg;

   typedef enum logic {
      RGGEN_READ  = 1'b0,
      RGGEN_WRITE = 1'b1
   } rggen_direction;

   typedef enum logic [1:0] {
      RGGEN_OKAY          = 2'b00,
      RGGEN_EXOKAY        = 2'b01,
      RGGEN_SLAVE_ERROR   = 2'b10,
      RGGEN_ADDRESS_ERROR = 2'b11
   } rggen_status;

   // Index width that stays legal (at least 1 bit) for a single-entry set.
   function automatic int rggen_id_width(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rggen_round_robin_select.sv
// Combinational round-robin pick: first requester strictly after last_grant,
// found by priority-encoding a doubled, masked copy of the request vector.
module rggen_round_robin_select
   import rggen_rtl_pkg::*;
#(
   parameter  int N    = 2,
   localparam int ID_W = rggen_id_width(N)
)(
   input  logic [N-1:0]    request,
   input  logic [ID_W-1:0] last_grant,
   output logic            found,
   output logic [ID_W-1:0] select_id
);

   logic [2*N-1:0] request_x2;
   logic [2*N-1:0] masked;

   assign request_x2 = {request, request};

   // The upper copy is never masked, so the search always wraps around.
   generate
      for (genvar gi = 0; gi < 2*N; gi++) begin : g_mask
         assign masked[gi] = request_x2[gi] && (gi > int'(last_grant));
      end
   endgenerate

   always_comb begin
      select_id = '0;
      for (int i = 2*N-1; i >= 0; i--) begin
         if (masked[i]) begin
            select_id = ID_W'((i >= N) ? (i - N) : i);
         end
      end
   end

   assign found = |request;

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin sharing of one register-bus master among NUM_HOSTS requesters;
// the granted command is held until bus_done and completion goes to the winner.
module rggen_bus_arbiter
   import rggen_rtl_pkg::*;
#(
   parameter  int NUM_HOSTS     = 2,
   parameter  int ADDRESS_WIDTH = 16,
   parameter  int DATA_WIDTH    = 32,
   localparam int ID_W          = rggen_id_width(NUM_HOSTS),
   localparam int STRB_W        = DATA_WIDTH / 8
)(
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_HOSTS-1:0]                   host_request,
   input  logic [NUM_HOSTS-1:0][ADDRESS_WIDTH-1:0] host_address,
   input  logic [NUM_HOSTS-1:0]                   host_direction,
   input  logic [NUM_HOSTS-1:0][DATA_WIDTH-1:0]   host_write_data,
   input  logic [NUM_HOSTS-1:0][STRB_W-1:0]       host_write_strobe,
   output logic [NUM_HOSTS-1:0]                   host_done,
   output logic [DATA_WIDTH-1:0]                  host_read_data,
   output logic [1:0]                             host_status,
   output logic                                   bus_request,
   output logic [ADDRESS_WIDTH-1:0]               bus_address,
   output logic                                   bus_direction,
   output logic [DATA_WIDTH-1:0]                  bus_write_data,
   output logic [STRB_W-1:0]                      bus_write_strobe,
   input  logic                                   bus_done,
   input  logic [DATA_WIDTH-1:0]                  bus_read_data,
   input  logic [1:0]                             bus_status
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                   state_reg;
   state_t                   state_next;
   logic                     found;
   logic [ID_W-1:0]          select_id;
   logic [ID_W-1:0]          grant_id_reg;
   logic [ID_W-1:0]          last_grant_reg;
   logic [ADDRESS_WIDTH-1:0] cmd_address_reg;
   logic                     cmd_direction_reg;
   logic [DATA_WIDTH-1:0]    cmd_write_data_reg;
   logic [STRB_W-1:0]        cmd_write_strobe_reg;

   generate
      if (NUM_HOSTS > 1) begin : g_arbiter
         rggen_round_robin_select #(
            .N (NUM_HOSTS)
         ) u_select (
            .request    (host_request),
            .last_grant (last_grant_reg),
            .found      (found),
            .select_id  (select_id)
         );
      end else begin : g_single
         assign found     = host_request[0];
         assign select_id = '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (found)    state_next = BUSY;
         BUSY:    if (bus_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Command is captured only when leaving IDLE, so host changes during BUSY are ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_reg       <= ID_W'(NUM_HOSTS - 1);
         grant_id_reg         <= '0;
         cmd_address_reg      <= '0;
         cmd_direction_reg    <= RGGEN_READ;
         cmd_write_data_reg   <= '0;
         cmd_write_strobe_reg <= '0;
      end else begin
         if ((state_reg == IDLE) && found) begin
            grant_id_reg         <= select_id;
            cmd_address_reg      <= host_address[select_id];
            cmd_direction_reg    <= host_direction[select_id];
            cmd_write_data_reg   <= host_write_data[select_id];
            cmd_write_strobe_reg <= host_write_strobe[select_id];
         end
         if ((state_reg == BUSY) && bus_done) begin
            last_grant_reg <= grant_id_reg;
         end
      end
   end

   always_comb begin
      bus_request    = (state_reg == BUSY);
      host_done      = '0;
      host_read_data = '0;
      host_status    = RGGEN_OKAY;
      if (state_reg == BUSY) begin
         host_read_data = bus_read_data;
         host_status    = bus_status;
         if (bus_done) begin
            host_done[grant_id_reg] = 1'b1;
         end
      end
   end

   assign bus_address      = cmd_address_reg;
   assign bus_direction    = cmd_direction_reg;
   assign bus_write_data   = cmd_write_data_reg;
   assign bus_write_strobe = cmd_write_strobe_reg;

endmodule
